// File: rtl/stream2di_ring_pkg.sv
// Shared types and constants for the stream-to-DI frame ring.
`include "dtypes.sv"

package stream2di_ring_pkg;

  localparam int DTYPE_WIDTH = `DTYPE_WIDTH;

  localparam logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_START = `DTYPE_FRAME_START;
  localparam logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_END   = `DTYPE_FRAME_END;
  localparam logic [DTYPE_WIDTH-1:0] DTYPE_PIXEL_MASK  = `DTYPE_PIXEL_MASK;

  // Saturation point of the dropped-frame counter.
  localparam logic [15:0] DROP_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    WIDLE    = 2'd0,
    WCAPTURE = 2'd1,
    WDROP    = 2'd2
  } wstate_e;

  typedef enum logic {
    RWAIT   = 1'b0,
    READING = 1'b1
  } rstate_e;

  // Any bit inside the pixel mask marks the beat as carrying a pixel.
  function automatic logic is_pixel(input logic [DTYPE_WIDTH-1:0] dtype);
    return |(dtype & DTYPE_PIXEL_MASK);
  endfunction

endpackage

// File: rtl/dtypes.sv
// Shared stream data-type tags carried on dtypei alongside each pixel beat.
`ifndef DTYPES_V
`define DTYPES_V
`define DTYPE_WIDTH       8
`define DTYPE_FRAME_START 8'h01
`define DTYPE_FRAME_END   8'h02
`define DTYPE_ROW_START   8'h04
`define DTYPE_ROW_END     8'h08
`define DTYPE_PIXEL_MASK  8'hF0
`endif

// File: rtl/stream2di_ram.sv
// Simple dual-port frame RAM: one write port, one read port with an output register.
module stream2di_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_BITS  = 14
) (
  input  logic                  resetb,
  input  logic                  clki,
  input  logic                  clear,
  input  logic                  we,
  input  logic [ADDR_BITS-1:0]  waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_BITS-1:0]  raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_r [2**ADDR_BITS];

  // Storage array write; the array itself is never reset.
  always_ff @(posedge clki) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Registered read port; the output register clears so the bus reads zero after reset.
  always_ff @(posedge clki or negedge resetb) begin
    if (!resetb) begin
      rdata <= {DATA_WIDTH{1'b0}};
    end else if (clear) begin
      rdata <= {DATA_WIDTH{1'b0}};
    end else begin
      rdata <= mem_r[raddr];
    end
  end

endmodule

// File: rtl/stream2di_ring.sv
// Captures tagged pixel frames into a ring of buffers and serves whole frames over DI.
module stream2di_ring
  import stream2di_ring_pkg::*;
#(
  parameter int ADDR_WIDTH        = 12,
  parameter int NUM_BUFS          = 4,
  parameter int DI_DATA_WIDTH     = 32,
  parameter int STREAM_DATA_WIDTH = 16
) (
  input  logic                         resetb,
  input  logic                         clki,
  input  logic                         enable,
  input  logic                         dvi,
  input  logic [DTYPE_WIDTH-1:0]       dtypei,
  input  logic [STREAM_DATA_WIDTH-1:0] datai,
  input  logic                         di_read_mode,
  input  logic                         di_read,
  output logic                         di_read_rdy,
  output logic [DI_DATA_WIDTH-1:0]     di_reg_datao,
  output logic [ADDR_WIDTH:0]          frame_len,
  output logic [$clog2(NUM_BUFS):0]    frames_avail,
  output logic [15:0]                  drop_count,
  output logic                         overflow
);

  localparam int PACK       = DI_DATA_WIDTH / STREAM_DATA_WIDTH;
  localparam int BUF_BITS   = $clog2(NUM_BUFS);
  localparam int PHASE_BITS = (PACK > 1) ? $clog2(PACK) : 1;

  localparam logic [ADDR_WIDTH:0]    CAPACITY   = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]    ADDR_ZERO  = {(ADDR_WIDTH+1){1'b0}};
  localparam logic [ADDR_WIDTH:0]    ADDR_ONE   = (ADDR_WIDTH+1)'(1);
  localparam logic [PHASE_BITS-1:0]  PHASE_ZERO = {PHASE_BITS{1'b0}};
  localparam logic [PHASE_BITS-1:0]  PHASE_ONE  = PHASE_BITS'(1);
  localparam logic [PHASE_BITS-1:0]  PHASE_LAST = PHASE_BITS'(PACK - 1);
  localparam logic [BUF_BITS-1:0]    PTR_ZERO   = {BUF_BITS{1'b0}};
  localparam logic [BUF_BITS-1:0]    PTR_ONE    = BUF_BITS'(1);
  localparam logic [BUF_BITS:0]      AVAIL_ZERO = {(BUF_BITS+1){1'b0}};
  localparam logic [BUF_BITS:0]      AVAIL_ONE  = (BUF_BITS+1)'(1);
  localparam logic [BUF_BITS:0]      AVAIL_FULL = (BUF_BITS+1)'(NUM_BUFS);
  localparam logic [DI_DATA_WIDTH-1:0] WORD_ZERO = {DI_DATA_WIDTH{1'b0}};

  // Write side state
  wstate_e                  wstate_r, wstate_next_s;
  logic [ADDR_WIDTH:0]      waddr_r, waddr_next_s;
  logic [PHASE_BITS-1:0]    phase_r, phase_next_s;
  logic [DI_DATA_WIDTH-1:0] lanes_r, lanes_next_s, merged_s;
  logic [BUF_BITS-1:0]      wptr_r;
  logic                     ram_we_s;
  logic [ADDR_WIDTH-1:0]    ram_waddr_s;
  logic [DI_DATA_WIDTH-1:0] ram_wdata_s;
  logic                     commit_s;
  logic [ADDR_WIDTH:0]      commit_len_s;
  logic                     drop_s;
  logic                     overflow_set_s;

  // Read side state
  rstate_e                  rstate_r, rstate_next_s;
  logic [ADDR_WIDTH:0]      raddr_r, raddr_next_s;
  logic [BUF_BITS-1:0]      rptr_r, rptr_next_s;
  logic                     release_s;
  logic                     rdy_r, rdy_next_s;

  // Shared bookkeeping
  logic [BUF_BITS:0]        frames_avail_r, frames_avail_next_s;
  logic [ADDR_WIDTH:0]      len_r [NUM_BUFS];
  logic [ADDR_WIDTH:0]      frame_len_r, frame_len_next_s;
  logic [15:0]              drop_count_r;
  logic                     overflow_r;

  logic                     is_start_s, is_end_s, is_pix_s;
  logic                     ram_clear_s;
  logic [DI_DATA_WIDTH-1:0] ram_rdata_s;

  assign is_start_s  = dvi && (dtypei == DTYPE_FRAME_START);
  assign is_end_s    = dvi && (dtypei == DTYPE_FRAME_END);
  assign is_pix_s    = dvi && is_pixel(dtypei);
  assign ram_clear_s = ~enable;

  // Pack the incoming pixel into its lane, LSB-first, on top of the lanes gathered so far.
  always_comb begin
    merged_s = lanes_r;
    merged_s[int'(phase_r) * STREAM_DATA_WIDTH +: STREAM_DATA_WIDTH] = datai;
  end

  // Write FSM: frame start/drop decisions, pixel packing, capacity clamp and commit.
  always_comb begin
    wstate_next_s  = wstate_r;
    waddr_next_s   = waddr_r;
    phase_next_s   = phase_r;
    lanes_next_s   = lanes_r;
    ram_we_s       = 1'b0;
    ram_waddr_s    = waddr_r[ADDR_WIDTH-1:0];
    ram_wdata_s    = lanes_r;
    commit_s       = 1'b0;
    commit_len_s   = waddr_r;
    drop_s         = 1'b0;
    overflow_set_s = 1'b0;
    case (wstate_r)
      WIDLE: begin
        if (is_start_s) begin
          if (frames_avail_r < AVAIL_FULL) begin
            wstate_next_s = WCAPTURE;
            waddr_next_s  = ADDR_ZERO;
            phase_next_s  = PHASE_ZERO;
            lanes_next_s  = WORD_ZERO;
          end else begin
            wstate_next_s = WDROP;
            drop_s        = 1'b1;
          end
        end else begin
          wstate_next_s = WIDLE;
        end
      end
      WCAPTURE: begin
        if (is_start_s) begin
          // Restart the same buffer; the abandoned frame is simply overwritten.
          waddr_next_s = ADDR_ZERO;
          phase_next_s = PHASE_ZERO;
          lanes_next_s = WORD_ZERO;
        end else if (is_end_s) begin
          if (phase_r != PHASE_ZERO) begin
            // Unfilled upper lanes are already zero in lanes_r.
            ram_we_s     = 1'b1;
            commit_len_s = waddr_r + ADDR_ONE;
          end else begin
            commit_len_s = waddr_r;
          end
          commit_s      = 1'b1;
          wstate_next_s = WIDLE;
          waddr_next_s  = ADDR_ZERO;
          phase_next_s  = PHASE_ZERO;
          lanes_next_s  = WORD_ZERO;
        end else if (is_pix_s) begin
          if (waddr_r == CAPACITY) begin
            overflow_set_s = 1'b1;
          end else if (phase_r == PHASE_LAST) begin
            ram_we_s     = 1'b1;
            ram_wdata_s  = merged_s;
            waddr_next_s = waddr_r + ADDR_ONE;
            phase_next_s = PHASE_ZERO;
            lanes_next_s = WORD_ZERO;
          end else begin
            lanes_next_s = merged_s;
            phase_next_s = phase_r + PHASE_ONE;
          end
        end else begin
          wstate_next_s = WCAPTURE;
        end
      end
      WDROP: begin
        if (is_end_s) begin
          wstate_next_s = WIDLE;
        end else begin
          wstate_next_s = WDROP;
        end
      end
      default: begin
        wstate_next_s = WIDLE;
      end
    endcase
  end

  // Read FSM: open a committed frame, advance on consumed words, release on mode fall.
  always_comb begin
    rstate_next_s = rstate_r;
    raddr_next_s  = raddr_r;
    release_s     = 1'b0;
    case (rstate_r)
      RWAIT: begin
        if (di_read_mode && (frames_avail_r != AVAIL_ZERO)) begin
          rstate_next_s = READING;
          raddr_next_s  = ADDR_ZERO;
        end else begin
          rstate_next_s = RWAIT;
        end
      end
      READING: begin
        if (!di_read_mode) begin
          rstate_next_s = RWAIT;
          raddr_next_s  = ADDR_ZERO;
          release_s     = 1'b1;
        end else if (di_read && rdy_r) begin
          raddr_next_s = raddr_r + ADDR_ONE;
        end else begin
          raddr_next_s = raddr_r;
        end
      end
      default: begin
        rstate_next_s = RWAIT;
      end
    endcase
  end

  // Pointer, occupancy, ready and head-length next values shared by both FSMs.
  always_comb begin
    rptr_next_s         = rptr_r;
    frames_avail_next_s = frames_avail_r;
    if (release_s) begin
      rptr_next_s = rptr_r + PTR_ONE;
    end else begin
      rptr_next_s = rptr_r;
    end
    if (commit_s && !release_s) begin
      frames_avail_next_s = frames_avail_r + AVAIL_ONE;
    end else if (!commit_s && release_s) begin
      frames_avail_next_s = frames_avail_r - AVAIL_ONE;
    end else begin
      frames_avail_next_s = frames_avail_r;
    end
    rdy_next_s = (rstate_next_s == READING) && (raddr_next_s < len_r[rptr_r]);
    // A commit into the head buffer must show up in frame_len the same cycle it lands in len_r.
    if (commit_s && (wptr_r == rptr_next_s)) begin
      frame_len_next_s = commit_len_s;
    end else begin
      frame_len_next_s = len_r[rptr_next_s];
    end
  end

  // Main state registers; enable low clears everything except the drop counter.
  always_ff @(posedge clki or negedge resetb) begin
    if (!resetb) begin
      wstate_r       <= WIDLE;
      waddr_r        <= ADDR_ZERO;
      phase_r        <= PHASE_ZERO;
      lanes_r        <= WORD_ZERO;
      wptr_r         <= PTR_ZERO;
      rstate_r       <= RWAIT;
      raddr_r        <= ADDR_ZERO;
      rptr_r         <= PTR_ZERO;
      rdy_r          <= 1'b0;
      frames_avail_r <= AVAIL_ZERO;
      frame_len_r    <= ADDR_ZERO;
      overflow_r     <= 1'b0;
      for (int i = 0; i < NUM_BUFS; i++) len_r[i] <= ADDR_ZERO;
    end else if (!enable) begin
      wstate_r       <= WIDLE;
      waddr_r        <= ADDR_ZERO;
      phase_r        <= PHASE_ZERO;
      lanes_r        <= WORD_ZERO;
      wptr_r         <= PTR_ZERO;
      rstate_r       <= RWAIT;
      raddr_r        <= ADDR_ZERO;
      rptr_r         <= PTR_ZERO;
      rdy_r          <= 1'b0;
      frames_avail_r <= AVAIL_ZERO;
      frame_len_r    <= ADDR_ZERO;
      overflow_r     <= 1'b0;
      for (int i = 0; i < NUM_BUFS; i++) len_r[i] <= ADDR_ZERO;
    end else begin
      wstate_r       <= wstate_next_s;
      waddr_r        <= waddr_next_s;
      phase_r        <= phase_next_s;
      lanes_r        <= lanes_next_s;
      rstate_r       <= rstate_next_s;
      raddr_r        <= raddr_next_s;
      rptr_r         <= rptr_next_s;
      rdy_r          <= rdy_next_s;
      frames_avail_r <= frames_avail_next_s;
      frame_len_r    <= frame_len_next_s;
      if (commit_s) begin
        len_r[wptr_r] <= commit_len_s;
        wptr_r        <= wptr_r + PTR_ONE;
      end
      if (overflow_set_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // Saturating dropped-frame counter; only resetb clears it.
  always_ff @(posedge clki or negedge resetb) begin
    if (!resetb) begin
      drop_count_r <= 16'h0000;
    end else if (enable && drop_s && (drop_count_r != DROP_MAX)) begin
      drop_count_r <= drop_count_r + 16'h0001;
    end
  end

  // Read address is the next raddr so the registered RAM output tracks raddr with no bubble.
  stream2di_ram #(
    .DATA_WIDTH (DI_DATA_WIDTH),
    .ADDR_BITS  (BUF_BITS + ADDR_WIDTH)
  ) u_ram (
    .resetb (resetb),
    .clki   (clki),
    .clear  (ram_clear_s),
    .we     (ram_we_s),
    .waddr  ({wptr_r, ram_waddr_s}),
    .wdata  (ram_wdata_s),
    .raddr  ({rptr_r, raddr_next_s[ADDR_WIDTH-1:0]}),
    .rdata  (ram_rdata_s)
  );

  assign di_read_rdy  = rdy_r;
  assign di_reg_datao = ram_rdata_s;
  assign frame_len    = frame_len_r;
  assign frames_avail = frames_avail_r;
  assign drop_count   = drop_count_r;
  assign overflow     = overflow_r;

endmodule

// File: tb/tb_stream2di_ring.sv
// Randomized self-checking bench for stream2di_ring with a pixel-list reference model.
module tb_stream2di_ring;
  import stream2di_ring_pkg::*;

  localparam int AW   = 6;
  localparam int NB   = 4;
  localparam int DW   = 32;
  localparam int SW   = 16;
  localparam int PACK = DW / SW;
  localparam int CAP_PIX = (2 ** AW) * PACK;

  logic           resetb, clki, enable, dvi, di_read_mode, di_read;
  logic [7:0]     dtypei;
  logic [SW-1:0]  datai;
  logic           di_read_rdy;
  logic [DW-1:0]  di_reg_datao;
  logic [AW:0]    frame_len;
  logic [2:0]     frames_avail;
  logic [15:0]    drop_count;
  logic           overflow;

  stream2di_ring #(
    .ADDR_WIDTH(AW), .NUM_BUFS(NB), .DI_DATA_WIDTH(DW), .STREAM_DATA_WIDTH(SW)
  ) dut (
    .resetb(resetb), .clki(clki), .enable(enable), .dvi(dvi), .dtypei(dtypei),
    .datai(datai), .di_read_mode(di_read_mode), .di_read(di_read),
    .di_read_rdy(di_read_rdy), .di_reg_datao(di_reg_datao), .frame_len(frame_len),
    .frames_avail(frames_avail), .drop_count(drop_count), .overflow(overflow)
  );

  initial clki = 1'b0;
  always #5 clki = ~clki;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: committed frames as a flat word list plus per-frame lengths.
  logic [DW-1:0] m_words [$];
  int            m_lens  [$];
  logic [SW-1:0] m_pix   [$];
  int            m_state;   // 0 idle, 1 capturing, 2 dropping
  int            m_drops;
  bit            m_ovf;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clki);
    #1;
  endtask

  task automatic model_clear(input bit keep_drops);
    m_words.delete(); m_lens.delete(); m_pix.delete();
    m_state = 0; m_ovf = 1'b0;
    if (!keep_drops) m_drops = 0;
  endtask

  task automatic model_commit();
    int n, nw;
    logic [DW-1:0] w;
    n = m_pix.size();
    if (n > CAP_PIX) begin m_ovf = 1'b1; n = CAP_PIX; end
    nw = (n + PACK - 1) / PACK;
    for (int k = 0; k < nw; k++) begin
      w = '0;
      for (int j = 0; j < PACK; j++)
        if (k * PACK + j < n) w = w | (DW'(m_pix[k * PACK + j]) << (j * SW));
      m_words.push_back(w);
    end
    m_lens.push_back(nw);
    m_pix.delete();
  endtask

  task automatic send(input logic [7:0] dt, input logic [SW-1:0] d);
    dvi = 1'b1; dtypei = dt; datai = d;
    step();
    dvi = 1'b0; dtypei = 8'h00; datai = '0;
    if (dt == DTYPE_FRAME_START) begin
      if (m_state == 1) m_pix.delete();
      else if (m_state == 0) begin
        if (m_lens.size() < NB) begin m_state = 1; m_pix.delete(); end
        else begin m_state = 2; if (m_drops < 65535) m_drops++; end
      end
    end else if (dt == DTYPE_FRAME_END) begin
      if (m_state == 1) model_commit();
      m_state = 0;
    end else if (is_pixel(dt) && m_state == 1) begin
      m_pix.push_back(d);
    end
  endtask

  task automatic send_frame(input int npix, input int base);
    send(DTYPE_FRAME_START, '0);
    for (int p = 0; p < npix; p++) send(8'h10, SW'(base + p));
    send(DTYPE_FRAME_END, '0);
  endtask

  task automatic check_status(input string tag);
    check_eq({tag, "_avail"}, frames_avail, m_lens.size());
    check_eq({tag, "_drops"}, drop_count, m_drops);
    check_eq({tag, "_ovf"}, overflow, m_ovf);
    if (m_lens.size() > 0) check_eq({tag, "_len"}, frame_len, m_lens[0]);
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_rdy"}, di_read_rdy, 0);
    check_eq({tag, "_data"}, di_reg_datao, 0);
    check_eq({tag, "_len"}, frame_len, 0);
    check_eq({tag, "_avail"}, frames_avail, 0);
    check_eq({tag, "_drops"}, drop_count, 0);
    check_eq({tag, "_ovf"}, overflow, 0);
  endtask

  // Read the frame at the head (if any) with random gaps, then release it.
  task automatic read_frame(input string tag);
    int n;
    logic [DW-1:0] w;
    di_read_mode = 1'b1;
    step();
    if (m_lens.size() == 0) begin
      check_eq({tag, "_empty_rdy"}, di_read_rdy, 0);
      di_read_mode = 1'b0;
      step();
      check_eq({tag, "_empty_avail"}, frames_avail, 0);
      return;
    end
    n = m_lens[0];
    check_eq({tag, "_flen"}, frame_len, n);
    for (int i = 0; i < n; i++) begin
      w = m_words.pop_front();
      check_eq({tag, "_rdy"}, di_read_rdy, 1);
      check_eq({tag, "_word"}, di_reg_datao, w);
      if ($urandom_range(0, 3) == 0) begin
        step();
        check_eq({tag, "_hold"}, di_reg_datao, w);
      end
      di_read = 1'b1;
      step();
      di_read = 1'b0;
    end
    check_eq({tag, "_rdy_end"}, di_read_rdy, 0);
    di_read = 1'b1;
    step();
    di_read = 1'b0;
    check_eq({tag, "_rdy_ign"}, di_read_rdy, 0);
    di_read_mode = 1'b0;
    step();
    void'(m_lens.pop_front());
    check_eq({tag, "_rel_rdy"}, di_read_rdy, 0);
    check_status({tag, "_rel"});
  endtask

  task automatic drain(input string tag);
    while (m_lens.size() > 0) read_frame(tag);
  endtask

  initial begin
    int np;
    resetb = 1'b0; enable = 1'b1; dvi = 1'b0; dtypei = 8'h00; datai = '0;
    di_read_mode = 1'b0; di_read = 1'b0;
    model_clear(1'b0);
    repeat (3) step();
    check_zero("reset");
    resetb = 1'b1;
    step();

    // Eight pixels pack into four words.
    send_frame(8, 1);
    check_eq("t1_len", frame_len, 4);
    check_eq("t1_w0_ref", m_words[0], 32'h0002_0001);
    check_status("t1");
    read_frame("t1");

    // Odd pixel count: partial last word zero-padded.
    send_frame(5, 1);
    check_eq("t2_len", frame_len, 3);
    check_eq("t2_last_ref", m_words[2], 32'h0000_0005);
    check_status("t2");
    read_frame("t2");

    // Five frames into four buffers: one drop.
    for (int f = 0; f < 5; f++) send_frame(2 + f, 16'h100 * (f + 1));
    check_eq("t3_avail", frames_avail, 4);
    check_eq("t3_drops", drop_count, 1);
    check_status("t3");
    drain("t3");

    // Restart inside a capture is not a drop.
    send(DTYPE_FRAME_START, '0);
    for (int p = 0; p < 3; p++) send(8'h10, SW'(16'h50 + p));
    send(DTYPE_FRAME_START, '0);
    send(8'h30, 16'hAAAA); send(8'h04, 16'h1234); send(8'h10, 16'hBBBB);
    send(DTYPE_FRAME_END, '0);
    check_eq("t4_len", frame_len, 1);
    check_eq("t4_drops", drop_count, 1);
    check_status("t4");
    read_frame("t4");

    // Over-capacity frame.
    send_frame(CAP_PIX + 3, 16'h1000);
    check_eq("t5_ovf", overflow, 1);
    check_eq("t5_len", frame_len, 2 ** AW);
    check_status("t5");
    read_frame("t5");

    // Enable low clears all but drop_count.
    for (int f = 0; f < 5; f++) send_frame(3, 16'h200 * f);
    check_status("t6_pre");
    enable = 1'b0;
    step();
    enable = 1'b1;
    model_clear(1'b1);
    check_eq("t6_avail", frames_avail, 0);
    check_eq("t6_drops", drop_count, 2);
    check_eq("t6_ovf", overflow, 0);
    check_eq("t6_len", frame_len, 0);
    send_frame(4, 16'h77);
    check_status("t6_post");
    read_frame("t6");
    read_frame("t6_none");

    // Randomized traffic with markers, idles, restarts and interleaved reads.
    for (int it = 0; it < 40; it++) begin
      np = $urandom_range(0, 20);
      if ($urandom_range(0, 4) == 0) send(8'h10, SW'($urandom));
      send(DTYPE_FRAME_START, '0);
      if ($urandom_range(0, 3) == 0) begin
        for (int p = 0; p < 3; p++) send(8'h20, SW'($urandom));
        send(DTYPE_FRAME_START, '0);
      end
      for (int p = 0; p < np; p++) begin
        case ($urandom_range(0, 5))
          0: step();
          1: send(8'h04, SW'($urandom));
          2: send(8'h08, SW'($urandom));
          default: ;
        endcase
        send(($urandom_range(0, 1) == 1) ? 8'h10 : 8'h30, SW'($urandom));
      end
      send(DTYPE_FRAME_END, '0);
      check_status("rnd");
      if ($urandom_range(0, 2) == 0) read_frame("rnd");
    end
    drain("rnd");

    // Reset mid-read.
    send_frame(6, 16'h300);
    di_read_mode = 1'b1;
    step();
    di_read = 1'b1;
    step();
    di_read = 1'b0;
    resetb = 1'b0;
    #1;
    check_zero("rst_read");
    di_read_mode = 1'b0;
    step();
    resetb = 1'b1;
    model_clear(1'b0);

    // Reset mid-capture.
    send(DTYPE_FRAME_START, '0);
    for (int p = 0; p < 3; p++) send(8'h10, SW'(16'h400 + p));
    resetb = 1'b0;
    #1;
    check_zero("rst_cap");
    step();
    resetb = 1'b1;
    model_clear(1'b0);
    send_frame(7, 16'h500);
    check_status("rst_after");
    read_frame("rst_after");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/stream2di_ring.md
Name: stream2di_ring

Overview:
- Captures imager frames from the dtype-tagged pixel stream into an NUM_BUFS-deep ring of frame buffers.
- Packs PACK pixels per DI word and returns whole frames over the DI register-read bus.
- Successor to the double-buffered capture model: parametrised pack ratio and buffer count, frame-drop accounting, per-frame length, zero-padded partial-word flush.
- Single clock domain; synthesizable RAM with a registered read port.

Parameters:
- ADDR_WIDTH, 12: log2 of DI words per buffer.
- NUM_BUFS, 4: number of frame buffers; power of 2, at least 2.
- DI_DATA_WIDTH, 32: DI read word width.
- STREAM_DATA_WIDTH, 16: pixel width. DI_DATA_WIDTH must be an integer multiple of it.
- PACK, DI_DATA_WIDTH/STREAM_DATA_WIDTH: derived pixels per word; not overridden.

Ports:
- resetb  in  1  asynchronous, active-low reset
- clki  in  1  clock for all logic
- enable  in  1  synchronous enable; low clears all state except drop_count
- dvi  in  1  stream data valid
- dtypei  in  `DTYPE_WIDTH  stream data type
- datai  in  STREAM_DATA_WIDTH  pixel data
- di_read_mode  in  1  high while the host is reading one frame
- di_read  in  1  word-consumed strobe
- di_read_rdy  out  1  di_reg_datao holds a valid word
- di_reg_datao  out  DI_DATA_WIDTH  current read word
- frame_len  out  ADDR_WIDTH+1  word count of the frame at the read head
- frames_avail  out  log2(NUM_BUFS)+1  committed, unreleased frames
- drop_count  out  16  frames dropped because the ring was full; saturating
- overflow  out  1  sticky: a frame exceeded buffer capacity

Behaviour:
- Reset: all outputs 0; wptr=rptr=0; both FSMs idle.
- enable low: same clear on the next clki edge, except drop_count, which holds.
- Write FSM states: WIDLE, WCAPTURE, WDROP.
- WIDLE, dvi with `DTYPE_FRAME_START:
  - frames_avail<NUM_BUFS -> WCAPTURE; waddr=0, phase=0.
  - otherwise -> WDROP; drop_count+1, saturating at 0xFFFF.
- WCAPTURE, dvi with dtypei&`DTYPE_PIXEL_MASK nonzero:
  - Pixel goes into lane phase, LSB-first.
  - When phase==PACK-1: write the word to buf[wptr][waddr], waddr+1, phase=0.
- Capacity: when waddr reaches 2^ADDR_WIDTH, further pixels are discarded and overflow is set.
- WCAPTURE, `DTYPE_FRAME_END:
  - If phase!=0, write the partial word with unfilled upper lanes = 0 and count it.
  - Store the length in len[wptr], wptr+1 (mod NUM_BUFS), frames_avail+1, -> WIDLE.
- FRAME_START while in WCAPTURE: abandon the current frame and restart the same buffer at waddr=0. Not counted as a drop.
- WDROP ignores everything until FRAME_END, then -> WIDLE.
- Non-pixel, non-frame dtypes (row markers etc.) are ignored in all states.
- Read FSM states: RWAIT, READING.
  - RWAIT: di_read_mode=1 and frames_avail>0 -> READING, raddr=0.
  - READING: di_read_rdy=1 while raddr<len[rptr]; 0 once raddr==len[rptr].
  - di_read while rdy -> raddr+1. di_read while rdy=0 is ignored.
- Leaving READING: di_read_mode falling releases the buffer (rptr+1, frames_avail-1, raddr=0, rdy=0) and goes to RWAIT.
- di_read_mode falling in RWAIT has no effect.
- Read latency: RAM read address is raddr_next, and di_reg_datao is the RAM output register. di_reg_datao therefore matches raddr every cycle with no bubble; first word valid on the cycle rdy rises.
- Simultaneous commit and release in one cycle: frames_avail unchanged, both pointers advance.
- frame_len = len[rptr]. frames_avail is 0..NUM_BUFS.

Decomposition:
- DTYPE_* constants and `DTYPE_WIDTH come from the shared dtypes.v; nothing new is added there.
- Sub-module stream2di_ram: simple dual-port RAM, depth NUM_BUFS*2^ADDR_WIDTH, write port plus registered read port, address = {buf_idx, word_addr}.
- Length table kept as a register array in the top module.

Test Plan:
- Frame of 8 pixels 0x0001..0x0008, PACK=2, then read mode -> rdy, words 0x00020001..0x00080007, frame_len=4, rdy drops after the 4th read.
- Frame of 5 pixels -> frame_len=3, last word 0x00000005.
- 5 frames with NUM_BUFS=4 and no reads -> frames_avail=4, drop_count=1; readback returns frames 1-4 in order.
- FRAME_START, 3 pixels, FRAME_START, 2 pixels, FRAME_END -> single frame, frame_len=1, drop_count=0.
- Frame longer than 2^ADDR_WIDTH*PACK pixels -> overflow=1, frame_len=2^ADDR_WIDTH.
- Assert resetb low mid-capture and mid-read -> all outputs 0 immediately; next full frame captures and reads back cleanly.
